// File: rtl/game_core.sv
// game_core: menu FSM, active-slot selection, cursor navigation and a bank of
// modulo counters with wrap flags and a buzzer request. Optional macro
// GAME_CORE_ALARM_LATCH_EN makes the alarm a level held while any wrap flag is set.
module game_core #(
  parameter int N_SLOTS    = 10,
  parameter int DIGIT_W    = 4,
  parameter int MODULUS    = 10,
  parameter int INIT_DIGIT = 1,
  parameter int IDX_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  parameter int CNT_W      = $clog2(N_SLOTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  output logic [1:0]                   state,
  output logic [CNT_W-1:0]             active_cnt,
  output logic [IDX_W-1:0]             cursor,
  output logic [N_SLOTS*DIGIT_W-1:0]   status,
  output logic [N_SLOTS-1:0]           wrap_flags,
  output logic                         alarm
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_HELP   = 2'd1,
    ST_SELECT = 2'd2,
    ST_PLAY   = 2'd3
  } state_e;

  localparam logic [3:0] KEY_UP    = 4'd2;
  localparam logic [3:0] KEY_DOWN  = 4'd6;
  localparam logic [3:0] KEY_LEFT  = 4'd7;
  localparam logic [3:0] KEY_RIGHT = 4'd5;
  localparam logic [3:0] KEY_ACK   = 4'd10;
  localparam logic [3:0] KEY_EXIT  = 4'd12;
  localparam logic [3:0] KEY_BACK  = 4'd13;
  localparam logic [3:0] KEY_NEXT  = 4'd14;
  localparam logic [3:0] KEY_HELP  = 4'd15;

  localparam logic [DIGIT_W-1:0] DIG_MAX  = DIGIT_W'(MODULUS - 1);
  localparam logic [DIGIT_W-1:0] DIG_INIT = DIGIT_W'(INIT_DIGIT);
  localparam logic [DIGIT_W-1:0] DIG_ONE  = DIGIT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(N_SLOTS);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           cur_q, cur_d;
  logic [DIGIT_W-1:0]         slot_q [N_SLOTS];
  logic [DIGIT_W-1:0]         slot_d [N_SLOTS];
  logic [N_SLOTS-1:0]         flags_q, flags_d;
  logic                       alarm_q, alarm_d;
  logic                       wrap_evt;
  logic [CNT_W-1:0]           cnt_m1;
  logic [IDX_W-1:0]           last_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    slot_d   = slot_q;
    flags_d  = flags_q;
    wrap_evt = 1'b0;
    cnt_m1   = cnt_q - CNT_ONE;
    last_idx = IDX_W'(cnt_m1);

    if (key_valid) begin
      unique case (state_q)
        ST_START: begin
          if (key_code == KEY_HELP)      state_d = ST_HELP;
          else if (key_code == KEY_NEXT) state_d = ST_SELECT;
        end
        ST_HELP: begin
          if (key_code == KEY_BACK)      state_d = ST_START;
          else if (key_code == KEY_NEXT) state_d = ST_SELECT;
        end
        ST_SELECT: begin
          case (key_code)
            KEY_UP:   if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            KEY_DOWN: if (cnt_q > CNT_ONE) cnt_d = cnt_m1;
            KEY_EXIT: state_d = ST_START;
            KEY_NEXT: begin
              state_d = ST_PLAY;
              cur_d   = '0;
              flags_d = '0;
              for (int i = 0; i < N_SLOTS; i++) slot_d[i] = DIG_INIT;
            end
            default: ;
          endcase
        end
        ST_PLAY: begin
          case (key_code)
            KEY_LEFT:  cur_d = (cur_q == '0) ? last_idx : cur_q - IDX_ONE;
            KEY_RIGHT: cur_d = (cur_q == last_idx) ? '0 : cur_q + IDX_ONE;
            KEY_UP: begin
              for (int i = 0; i < N_SLOTS; i++) begin
                if (IDX_W'(i) == cur_q) begin
                  if (slot_q[i] == DIG_MAX) begin
                    slot_d[i]  = '0;
                    flags_d[i] = 1'b1;
                    wrap_evt   = 1'b1;
                  end else begin
                    slot_d[i] = slot_q[i] + DIG_ONE;
                  end
                end
              end
            end
            KEY_DOWN: begin
              for (int i = 0; i < N_SLOTS; i++) begin
                if (IDX_W'(i) == cur_q)
                  slot_d[i] = (slot_q[i] == '0) ? DIG_MAX : slot_q[i] - DIG_ONE;
              end
            end
            KEY_ACK: flags_d = '0;
            KEY_EXIT: begin
              state_d = ST_START;
              flags_d = '0;
              for (int i = 0; i < N_SLOTS; i++) slot_d[i] = DIG_INIT;
            end
            default: ;
          endcase
        end
        default: state_d = ST_START;
      endcase
    end

`ifdef GAME_CORE_ALARM_LATCH_EN
    alarm_d = |flags_d;
`else
    alarm_d = wrap_evt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      cnt_q   <= CNT_ONE;
      cur_q   <= '0;
      flags_q <= '0;
      alarm_q <= 1'b0;
      // NOTE: the slot bank is a visible register file with a defined load value, so it is reset.
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= DIG_INIT;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      flags_q <= flags_d;
      alarm_q <= alarm_d;
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    status = '0;
    for (int i = 0; i < N_SLOTS; i++) status[i*DIGIT_W +: DIGIT_W] = slot_q[i];
  end

  assign state      = state_q;
  assign active_cnt = cnt_q;
  assign cursor     = cur_q;
  assign wrap_flags = flags_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_game_core.sv
// Self-checking bench for game_core: directed scenarios plus a randomized
// back-to-back key stream, all compared against a behavioural game model.
module tb_game_core;

  localparam int N     = 10;
  localparam int DW    = 4;
  localparam int MOD   = 10;
  localparam int INIT  = 1;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int BUS_W = 2 + CNT_W + IDX_W + N*DW + N + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               key_valid;
  logic [3:0]         key_code;
  logic [1:0]         state;
  logic [CNT_W-1:0]   active_cnt;
  logic [IDX_W-1:0]   cursor;
  logic [N*DW-1:0]    status;
  logic [N-1:0]       wrap_flags;
  logic               alarm;
  logic [BUS_W-1:0]   dut_bus;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model of the game
  int m_state, m_cnt, m_cur;
  int m_slot [N];
  bit m_flag [N];
  bit m_alarm;

  game_core #(
    .N_SLOTS(N), .DIGIT_W(DW), .MODULUS(MOD), .INIT_DIGIT(INIT),
    .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .state(state), .active_cnt(active_cnt), .cursor(cursor),
    .status(status), .wrap_flags(wrap_flags), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign dut_bus = {state, active_cnt, cursor, status, wrap_flags, alarm};

  function automatic logic [BUS_W-1:0] exp_bus();
    logic [N*DW-1:0] st;
    logic [N-1:0]    fl;
    for (int i = 0; i < N; i++) begin
      st[i*DW +: DW] = DW'(m_slot[i]);
      fl[i]          = m_flag[i];
    end
    return {2'(m_state), CNT_W'(m_cnt), IDX_W'(m_cur), st, fl, m_alarm};
  endfunction

  task automatic m_reset();
    m_state = 0; m_cnt = 1; m_cur = 0; m_alarm = 1'b0;
    for (int i = 0; i < N; i++) begin m_slot[i] = INIT; m_flag[i] = 1'b0; end
  endtask

  task automatic m_step(input bit v, input int k);
    bit wrap = 1'b0;
    bit any  = 1'b0;
    if (v) begin
      case (m_state)
        0: if (k == 15) m_state = 1; else if (k == 14) m_state = 2;
        1: if (k == 13) m_state = 0; else if (k == 14) m_state = 2;
        2: begin
          if (k == 2 && m_cnt < N) m_cnt++;
          else if (k == 6 && m_cnt > 1) m_cnt--;
          else if (k == 12) m_state = 0;
          else if (k == 14) begin
            m_state = 3; m_cur = 0;
            for (int i = 0; i < N; i++) begin m_slot[i] = INIT; m_flag[i] = 1'b0; end
          end
        end
        default: begin
          case (k)
            7:  m_cur = (m_cur + m_cnt - 1) % m_cnt;
            5:  m_cur = (m_cur + 1) % m_cnt;
            2: begin
              m_slot[m_cur] = (m_slot[m_cur] + 1) % MOD;
              if (m_slot[m_cur] == 0) begin m_flag[m_cur] = 1'b1; wrap = 1'b1; end
            end
            6:  m_slot[m_cur] = (m_slot[m_cur] + MOD - 1) % MOD;
            10: for (int i = 0; i < N; i++) m_flag[i] = 1'b0;
            12: begin
              m_state = 0;
              for (int i = 0; i < N; i++) begin m_slot[i] = INIT; m_flag[i] = 1'b0; end
            end
            default: ;
          endcase
        end
      endcase
    end
    for (int i = 0; i < N; i++) any |= m_flag[i];
`ifdef GAME_CORE_ALARM_LATCH_EN
    m_alarm = any;
`else
    m_alarm = wrap;
`endif
  endtask

  // Drive one clock cycle of input from a falling edge to the next falling edge.
  task automatic cycle(input bit v, input int k);
    key_valid = v;
    key_code  = 4'(k);
    m_step(v, k);
    @(negedge clk);
  endtask

  task automatic press(input int k);
    cycle(1'b1, k);
  endtask

  task automatic test_reset();
    rst = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    m_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL reset_held: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
    rst = 1'b1;
    cycle(1'b0, 0);
    cycle(1'b1, 3);
    n_total++;
    if (status !== 40'h1111111111) $display("FAIL reset_status: got %h exp 1111111111", status);
    else n_pass++;
    n_total++;
    if ({state, active_cnt, alarm} !== {2'd0, 4'd1, 1'b0})
      $display("FAIL reset_ctrl: got state=%0d cnt=%0d alarm=%0b exp 0 1 0", state, active_cnt, alarm);
    else n_pass++;
  endtask

  task automatic test_menu();
    press(15);
    n_total++;
    if (state !== 2'd1) $display("FAIL menu_help: got %0d exp 1", state); else n_pass++;
    press(13);
    n_total++;
    if (state !== 2'd0) $display("FAIL menu_back: got %0d exp 0", state); else n_pass++;
    press(14);
    n_total++;
    if (state !== 2'd2) $display("FAIL menu_select: got %0d exp 2", state); else n_pass++;
    press(2); press(2);
    n_total++;
    if (active_cnt !== 4'd3) $display("FAIL menu_cnt: got %0d exp 3", active_cnt); else n_pass++;
    press(14);
    n_total++;
    if ({state, cursor} !== {2'd3, 4'd0})
      $display("FAIL menu_play: got state=%0d cur=%0d exp 3 0", state, cursor);
    else n_pass++;
  endtask

  task automatic test_cursor_wrap();
    press(7);
    n_total++;
    if (cursor !== 4'd2) $display("FAIL cursor_left_wrap: got %0d exp 2", cursor); else n_pass++;
    press(5); press(5);
    n_total++;
    if (cursor !== 4'd1) $display("FAIL cursor_right_wrap: got %0d exp 1", cursor); else n_pass++;
    press(7);
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL cursor_state: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
  endtask

  task automatic test_increment_wrap();
    for (int i = 0; i < 8; i++) press(2);
    n_total++;
    if ({status[3:0], wrap_flags[0], alarm} !== {4'd9, 1'b0, 1'b0})
      $display("FAIL inc_pre_wrap: got slot=%0d flag=%0b alarm=%0b exp 9 0 0", status[3:0], wrap_flags[0], alarm);
    else n_pass++;
    press(2);
    n_total++;
    if ({status[3:0], wrap_flags[0], alarm} !== {4'd0, 1'b1, 1'b1})
      $display("FAIL inc_wrap: got slot=%0d flag=%0b alarm=%0b exp 0 1 1", status[3:0], wrap_flags[0], alarm);
    else n_pass++;
    cycle(1'b0, 0); cycle(1'b0, 2); cycle(1'b1, 11);
`ifdef GAME_CORE_ALARM_LATCH_EN
    n_total++;
    if (alarm !== 1'b1) $display("FAIL alarm_held: got %0b exp 1", alarm); else n_pass++;
`else
    n_total++;
    if (alarm !== 1'b0) $display("FAIL alarm_pulse: got %0b exp 0", alarm); else n_pass++;
`endif
    n_total++;
    if (wrap_flags[0] !== 1'b1) $display("FAIL flag_latched: got %0b exp 1", wrap_flags[0]); else n_pass++;
    press(10);
    n_total++;
    if ({wrap_flags, alarm} !== 11'd0)
      $display("FAIL ack: got flags=%h alarm=%0b exp 0 0", wrap_flags, alarm);
    else n_pass++;
  endtask

  task automatic test_decrement();
    press(6);
    n_total++;
    if ({status[3:0], wrap_flags} !== {4'd9, 10'd0})
      $display("FAIL dec_wrap: got slot=%0d flags=%h exp 9 0", status[3:0], wrap_flags);
    else n_pass++;
    press(2); press(6); press(2);
    n_total++;
    if ({status[3:0], wrap_flags[0]} !== {4'd0, 1'b1})
      $display("FAIL rewrap_flag_set: got slot=%0d flag=%0b exp 0 1", status[3:0], wrap_flags[0]);
    else n_pass++;
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL dec_state: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
    press(10);
  endtask

  task automatic test_exit_and_saturation();
    press(5); press(2);
    press(12);
    n_total++;
    if ({state, active_cnt, status, wrap_flags} !== {2'd0, 4'd3, 40'h1111111111, 10'd0})
      $display("FAIL exit: got state=%0d cnt=%0d status=%h flags=%h exp 0 3 1111111111 0",
               state, active_cnt, status, wrap_flags);
    else n_pass++;
    press(14); press(6); press(6); press(6);
    n_total++;
    if (active_cnt !== 4'd1) $display("FAIL sat_low: got %0d exp 1", active_cnt); else n_pass++;
    for (int i = 0; i < 10; i++) press(2);
    n_total++;
    if (active_cnt !== 4'd10) $display("FAIL sat_high: got %0d exp 10", active_cnt); else n_pass++;
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL sat_state: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pool [5] = '{2, 6, 7, 5, 10};
    press(14);
    for (int n = 0; n < 600; n++) begin
      bit v = ($urandom_range(9) != 0);
      int k = ($urandom_range(3) != 0) ? pool[$urandom_range(4)] : int'($urandom_range(15));
      cycle(v, k);
      n_total++;
      if (dut_bus !== exp_bus())
        $display("FAIL random_%0d: key v=%0b k=%0d got %h exp %h", n, v, k, dut_bus, exp_bus());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_play();
    press(12); press(13); press(14); press(14);
    press(2); press(5); press(2); press(2);
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL pre_abort: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
    #3;
    rst = 1'b0; key_valid = 1'b0;
    m_reset();
    #1;
    n_total++;
    if (dut_bus !== exp_bus()) $display("FAIL abort_async: got %h exp %h", dut_bus, exp_bus());
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 0);
    n_total++;
    if ({state, active_cnt, cursor, status, wrap_flags, alarm} !==
        {2'd0, 4'd1, 4'd0, 40'h1111111111, 10'd0, 1'b0})
      $display("FAIL abort_release: got %h exp reset values", dut_bus);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_menu();
    test_cursor_wrap();
    test_increment_wrap();
    test_decrement();
    test_exit_and_saturation();
    test_back_to_back();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
